// File: rtl/vx_warp_ibuffer.sv
// Per-warp instruction buffer: one circular queue per warp, a round-robin
// arbiter over non-empty warps, and a registered valid/ready issue slot.
module vx_warp_ibuffer #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 4,
  parameter int DATAW     = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(NUM_WARPS)-1:0] in_wid,
  input  logic [DATAW-1:0]             in_data,
  input  logic                         flush_valid,
  input  logic [$clog2(NUM_WARPS)-1:0] flush_wid,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(NUM_WARPS)-1:0] out_wid,
  output logic [DATAW-1:0]             out_data,
  output logic [NUM_WARPS-1:0]         empty_mask,
  output logic [NUM_WARPS-1:0]         full_mask
);

  localparam int WIDW = $clog2(NUM_WARPS);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem    [NUM_WARPS][DEPTH];
  logic [PTRW-1:0]  wr_ptr [NUM_WARPS];
  logic [PTRW-1:0]  rd_ptr [NUM_WARPS];
  logic [CNTW-1:0]  count  [NUM_WARPS];
  logic [WIDW-1:0]  rr_ptr;

  logic [NUM_WARPS-1:0] flush_sel;
  logic [NUM_WARPS-1:0] push_sel;
  logic [NUM_WARPS-1:0] pop_sel;
  logic [NUM_WARPS-1:0] cand;
  logic                 load;
  logic                 found;
  logic [WIDW-1:0]      grant;
  logic [WIDW-1:0]      idx;

  always_comb begin
    load  = !out_valid || out_ready;
    found = 1'b0;
    grant = rr_ptr;
    idx   = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      flush_sel[w]  = flush_valid && (flush_wid == WIDW'(w));
      full_mask[w]  = (count[w] == CNTW'(DEPTH));
      empty_mask[w] = (count[w] == '0) && !(out_valid && (out_wid == WIDW'(w)));
      cand[w]       = (count[w] != '0) && !flush_sel[w];
    end
    in_ready = !full_mask[in_wid] && !(flush_valid && (flush_wid == in_wid));
    // Circular scan starting just after the last granted warp.
    for (int unsigned i = 1; i <= NUM_WARPS; i++) begin
      idx = WIDW'((32'(rr_ptr) + i) % NUM_WARPS);
      if (!found && cand[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      push_sel[w] = in_valid && in_ready && (in_wid == WIDW'(w));
      pop_sel[w]  = load && found && (grant == WIDW'(w));
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      mem[in_wid][wr_ptr[in_wid]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        count[w]  <= '0;
        wr_ptr[w] <= '0;
        rd_ptr[w] <= '0;
      end
      out_valid <= 1'b0;
      out_wid   <= '0;
      out_data  <= '0;
      rr_ptr    <= WIDW'(NUM_WARPS - 1);
    end else begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        if (flush_sel[w]) begin
          count[w]  <= '0;
          wr_ptr[w] <= '0;
          rd_ptr[w] <= '0;
        end else begin
          if (push_sel[w]) wr_ptr[w] <= wr_ptr[w] + PTRW'(1);
          if (pop_sel[w])  rd_ptr[w] <= rd_ptr[w] + PTRW'(1);
          if (push_sel[w] && !pop_sel[w]) begin
            count[w] <= count[w] + CNTW'(1);
          end else if (!push_sel[w] && pop_sel[w]) begin
            count[w] <= count[w] - CNTW'(1);
          end
        end
      end
      if (load) begin
        if (found) begin
          out_valid <= 1'b1;
          out_wid   <= grant;
          out_data  <= mem[grant][rd_ptr[grant]];
          rr_ptr    <= grant;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (flush_valid && out_valid && (out_wid == flush_wid)) begin
        // A stalled slot owned by the flushed warp is withdrawn.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// Bench for vx_warp_ibuffer: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_vx_warp_ibuffer;

  localparam int NW = 4;
  localparam int D  = 4;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_wid;
  logic [DW-1:0] in_data;
  logic          flush_valid;
  logic [1:0]    flush_wid;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_wid;
  logic [DW-1:0] out_data;
  logic [NW-1:0] empty_mask;
  logic [NW-1:0] full_mask;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] q [NW][$];

  always #5 clk = ~clk;

  vx_warp_ibuffer #(.NUM_WARPS(NW), .DEPTH(D), .DATAW(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_data(in_data),
    .flush_valid(flush_valid), .flush_wid(flush_wid),
    .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_data(out_data),
    .empty_mask(empty_mask), .full_mask(full_mask)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_wid = '0; in_data = '0;
    flush_valid = 1'b0; flush_wid = '0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input int w, input logic [DW-1:0] d);
    in_valid = 1'b1; in_wid = 2'(w); in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if ({out_valid, out_wid, out_data} !== '0) begin fails++;
      $display("FAIL rst_out: got v=%0d w=%0d d=%0h expected all 0", out_valid, out_wid, out_data); end
    tests++; if (empty_mask !== 4'b1111) begin fails++;
      $display("FAIL rst_empty: got %b expected 1111", empty_mask); end
    tests++; if (full_mask !== 4'b0000) begin fails++;
      $display("FAIL rst_full: got %b expected 0000", full_mask); end
    tests++; if (in_ready !== 1'b1) begin fails++;
      $display("FAIL rst_in_ready: got %0d expected 1", in_ready); end
  endtask

  task automatic test_latency();
    do_reset();
    out_ready = 1'b1;
    push(2, 64'hA5);
    tests++; if (out_valid !== 1'b0) begin fails++;
      $display("FAIL lat_cycle1_valid: got %0d expected 0", out_valid); end
    tests++; if (empty_mask !== 4'b1011) begin fails++;
      $display("FAIL lat_cycle1_empty: got %b expected 1011", empty_mask); end
    tick();
    tests++; if ({out_valid, out_wid, out_data} !== {1'b1, 2'd2, 64'hA5}) begin fails++;
      $display("FAIL lat_cycle2_out: got v=%0d w=%0d d=%0h expected v=1 w=2 d=a5", out_valid, out_wid, out_data); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++;
      $display("FAIL lat_drained_valid: got %0d expected 0", out_valid); end
    tests++; if (empty_mask !== 4'b1111) begin fails++;
      $display("FAIL lat_drained_empty: got %b expected 1111", empty_mask); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_wid = 2'd0; in_data = 64'(i);
      #1;
      tests++; if (in_ready !== 1'(i < 5)) begin fails++;
        $display("FAIL full_in_ready[%0d]: got %0d expected %0d", i, in_ready, (i < 5)); end
      if (i < 5) tick();
    end
    tests++; if (full_mask !== 4'b0001) begin fails++;
      $display("FAIL full_mask: got %b expected 0001", full_mask); end
    for (int w = 1; w < NW; w++) begin
      in_wid = 2'(w);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++;
        $display("FAIL full_other_ready[%0d]: got %0d expected 1", w, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tests++; if ({out_valid, out_data} !== {1'b1, 64'(k)}) begin fails++;
        $display("FAIL full_drain[%0d]: got v=%0d d=%0h expected v=1 d=%0h", k, out_valid, out_data, k); end
      tick();
    end
    tests++; if (out_valid !== 1'b0) begin fails++;
      $display("FAIL full_drain_end: got %0d expected 0", out_valid); end
  endtask

  task automatic test_round_robin();
    int ws [6] = '{0, 0, 1, 1, 3, 3};
    int exp_seq [6] = '{0, 1, 3, 0, 1, 3};
    do_reset();
    for (int i = 0; i < 6; i++) push(ws[i], 64'(ws[i] * 16 + i));
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tests++; if ({out_valid, out_wid} !== {1'b1, 2'(exp_seq[k])}) begin fails++;
        $display("FAIL rr_seq[%0d]: got v=%0d w=%0d expected v=1 w=%0d", k, out_valid, out_wid, exp_seq[k]); end
      tick();
    end
    tests++; if (out_valid !== 1'b0) begin fails++;
      $display("FAIL rr_end: got %0d expected 0", out_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    push(1, 64'h11);
    push(2, 64'h22);
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++; if ({out_valid, out_wid, out_data} !== {1'b1, 2'd1, 64'h11}) begin fails++;
        $display("FAIL stall_hold[%0d]: got v=%0d w=%0d d=%0h expected v=1 w=1 d=11", c, out_valid, out_wid, out_data); end
    end
    out_ready = 1'b1;
    tick();
    tests++; if ({out_valid, out_wid, out_data} !== {1'b1, 2'd2, 64'h22}) begin fails++;
      $display("FAIL stall_next: got v=%0d w=%0d d=%0h expected v=1 w=2 d=22", out_valid, out_wid, out_data); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++;
      $display("FAIL stall_end: got %0d expected 0", out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    push(1, 64'hA1); push(1, 64'hB1); push(1, 64'hC1);
    push(2, 64'hD2); push(2, 64'hE2);
    tests++; if ({out_valid, out_wid, out_data} !== {1'b1, 2'd1, 64'hA1}) begin fails++;
      $display("FAIL flush_pre: got v=%0d w=%0d d=%0h expected v=1 w=1 d=a1", out_valid, out_wid, out_data); end
    flush_valid = 1'b1; flush_wid = 2'd1;
    in_valid = 1'b1; in_wid = 2'd1; in_data = 64'hF1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++;
      $display("FAIL flush_in_ready: got %0d expected 0", in_ready); end
    tick();
    flush_valid = 1'b0; in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++;
      $display("FAIL flush_drop: got %0d expected 0", out_valid); end
    tests++; if (empty_mask !== 4'b1011) begin fails++;
      $display("FAIL flush_empty: got %b expected 1011", empty_mask); end
    out_ready = 1'b1;
    tick();
    tests++; if ({out_valid, out_wid, out_data} !== {1'b1, 2'd2, 64'hD2}) begin fails++;
      $display("FAIL flush_w2_a: got v=%0d w=%0d d=%0h expected v=1 w=2 d=d2", out_valid, out_wid, out_data); end
    tick();
    tests++; if ({out_valid, out_wid, out_data} !== {1'b1, 2'd2, 64'hE2}) begin fails++;
      $display("FAIL flush_w2_b: got v=%0d w=%0d d=%0h expected v=1 w=2 d=e2", out_valid, out_wid, out_data); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++;
      $display("FAIL flush_end: got %0d expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(0, 64'h01); push(0, 64'h02);
    push(1, 64'h11); push(1, 64'h12); push(1, 64'h13);
    push(2, 64'h21);
    reset = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++;
      $display("FAIL rmid_valid: got %0d expected 0", out_valid); end
    tests++; if (empty_mask !== 4'b1111) begin fails++;
      $display("FAIL rmid_empty: got %b expected 1111", empty_mask); end
    tests++; if (full_mask !== 4'b0000) begin fails++;
      $display("FAIL rmid_full: got %b expected 0000", full_mask); end
    reset = 1'b0;
    out_ready = 1'b1;
    push(0, 64'h77);
    tick();
    tests++; if ({out_valid, out_wid, out_data} !== {1'b1, 2'd0, 64'h77}) begin fails++;
      $display("FAIL rmid_first: got v=%0d w=%0d d=%0h expected v=1 w=0 d=77", out_valid, out_wid, out_data); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++;
      $display("FAIL rmid_stale: got %0d expected 0", out_valid); end
  endtask

  task automatic test_random();
    logic          m_ov;
    logic [1:0]    m_wid;
    logic [DW-1:0] m_data;
    int            m_rr;
    logic [NW-1:0] exp_empty, exp_full;
    logic          exp_ready, load;
    int            g, wi, rdy_pct;
    do_reset();
    for (int w = 0; w < NW; w++) q[w].delete();
    m_ov = 1'b0; m_wid = '0; m_data = '0; m_rr = NW - 1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tests++; if (out_valid !== m_ov) begin fails++;
        $display("FAIL rnd_valid@%0d: got %0d expected %0d", cyc, out_valid, m_ov); end
      if (m_ov) begin
        tests++; if ({out_wid, out_data} !== {m_wid, m_data}) begin fails++;
          $display("FAIL rnd_out@%0d: got w=%0d d=%0h expected w=%0d d=%0h", cyc, out_wid, out_data, m_wid, m_data); end
      end
      for (int w = 0; w < NW; w++) begin
        exp_empty[w] = (q[w].size() == 0) && !(m_ov && (m_wid == 2'(w)));
        exp_full[w]  = (q[w].size() == D);
      end
      tests++; if (empty_mask !== exp_empty) begin fails++;
        $display("FAIL rnd_empty@%0d: got %b expected %b", cyc, empty_mask, exp_empty); end
      tests++; if (full_mask !== exp_full) begin fails++;
        $display("FAIL rnd_full@%0d: got %b expected %b", cyc, full_mask, exp_full); end

      rdy_pct     = ((cyc / 200) % 2 == 0) ? 30 : 85;
      in_valid    = ($urandom_range(0, 99) < 75);
      in_wid      = 2'($urandom_range(0, NW - 1));
      in_data     = {$urandom, $urandom};
      flush_valid = ($urandom_range(0, 99) < 5);
      flush_wid   = 2'($urandom_range(0, NW - 1));
      out_ready   = ($urandom_range(0, 99) < rdy_pct);
      #1;
      exp_ready = (q[in_wid].size() < D) && !(flush_valid && (flush_wid == in_wid));
      tests++; if (in_ready !== exp_ready) begin fails++;
        $display("FAIL rnd_in_ready@%0d: got %0d expected %0d", cyc, in_ready, exp_ready); end

      load = !m_ov || out_ready;
      if (load) begin
        g = -1;
        for (int i = 1; i <= NW; i++) begin
          wi = (m_rr + i) % NW;
          if (g < 0 && q[wi].size() > 0 && !(flush_valid && flush_wid == 2'(wi))) g = wi;
        end
        if (g >= 0) begin
          m_ov = 1'b1; m_wid = 2'(g); m_data = q[g].pop_front(); m_rr = g;
        end else begin
          m_ov = 1'b0;
        end
      end else if (flush_valid && m_ov && m_wid == flush_wid) begin
        m_ov = 1'b0;
      end
      if (flush_valid) q[flush_wid].delete();
      if (in_valid && exp_ready) q[in_wid].push_back(in_data);
      tick();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_latency();
    test_full();
    test_round_robin();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
